// File: rtl/audio_dac_out.sv
// ---------------------------------------------------------------------------
// audio_dac_out
//
// Output stage that sits directly behind the voice mixer. It takes the
// signed mixed sample stream, applies a click-free ramped master gain and
// mute, and then runs a first-order delta-sigma modulator at the system
// clock. The single-bit output drives an external RC low-pass filter.
//
// Datapath:
//   capture  : s_q / gain_q are loaded on a sample_valid_i pulse; the gain
//              moves one code toward the target on each accepted sample.
//   scale    : one clock later, scaled_q = floor(s_q * gain_q / 2^GAIN_W).
//   modulate : every enabled clock, the offset-binary value of scaled_q is
//              added into acc_q; the carry out is the output bit.
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous, active-high reset
//   sample_i        signed two's-complement mixed audio sample
//   sample_valid_i  one-cycle pulse qualifying sample_i
//   volume_i        target master gain code (quasi-static)
//   mute_i          forces the target gain to 0
//   enable_i        modulator enable
//   dac_o           registered delta-sigma bitstream
//   gain_o          gain currently applied to samples
//   muted_o         high while the applied gain is 0
// ---------------------------------------------------------------------------
module audio_dac_out #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       sample_valid_i,
    input  logic        [GAIN_W-1:0]   volume_i,
    input  logic                       mute_i,
    input  logic                       enable_i,
    output logic                       dac_o,
    output logic        [GAIN_W-1:0]   gain_o,
    output logic                       muted_o
);

    // Product keeps the full signed range of sample x unsigned gain code.
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Signed sample times unsigned gain code, arithmetic shift right by
    // GAIN_W (floor toward -inf), truncated back to the sample width. The
    // largest gain is (2^GAIN_W - 1) / 2^GAIN_W, so truncation never wraps.
    function automatic logic signed [SAMPLE_W-1:0] scale_sample(
        input logic signed [SAMPLE_W-1:0] s,
        input logic        [GAIN_W-1:0]   g
    );
        logic signed [PROD_W-1:0] s_ext;
        logic signed [PROD_W-1:0] g_ext;
        logic signed [PROD_W-1:0] prod;
        s_ext = {{(PROD_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
        g_ext = {{(PROD_W-GAIN_W){1'b0}}, g};
        prod  = s_ext * g_ext;
        return SAMPLE_W'(prod >>> GAIN_W);
    endfunction

    // One-code step toward the target; never jumps.
    function automatic logic [GAIN_W-1:0] ramp_step(
        input logic [GAIN_W-1:0] cur,
        input logic [GAIN_W-1:0] tgt
    );
        if (cur < tgt) begin
            return cur + GAIN_W'(1);
        end else if (cur > tgt) begin
            return cur - GAIN_W'(1);
        end else begin
            return cur;
        end
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic signed [SAMPLE_W-1:0] s_q;
    logic        [GAIN_W-1:0]   gain_q;
    logic                       muted_q;
    logic                       vld_p1;
    logic signed [SAMPLE_W-1:0] scaled_q;
    logic        [SAMPLE_W-1:0] acc_q;
    logic                       dac_q;

    logic        [GAIN_W-1:0]   tgt;
    logic        [GAIN_W-1:0]   gain_next;
    logic        [SAMPLE_W-1:0] u;
    logic        [SAMPLE_W:0]   sum;

    // Target is only acted on when a sample is accepted, so mute/volume
    // changes mid-ramp simply re-aim the next step.
    always_comb begin
        tgt       = mute_i ? '0 : volume_i;
        gain_next = ramp_step(gain_q, tgt);
    end

    // -----------------------------------------------------------------------
    // Stage 0: capture sample and step the gain
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q     <= '0;
            gain_q  <= '0;
            muted_q <= 1'b1;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= sample_valid_i;
            if (sample_valid_i) begin
                s_q     <= sample_i;
                gain_q  <= gain_next;
                // Registered alongside gain_q so the flag is a clean flop
                // output rather than a comparator on the gain bus.
                muted_q <= (gain_next == '0);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: scale; result holds until the next accepted sample
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scaled_q <= '0;
        end else if (vld_p1) begin
            scaled_q <= scale_sample(s_q, gain_q);
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: first-order delta-sigma modulator
    // -----------------------------------------------------------------------
    // Inverting the MSB maps signed to offset binary (midscale = 0x8000), so
    // the carry density equals u / 2^SAMPLE_W.
    always_comb begin
        u   = {~scaled_q[SAMPLE_W-1], scaled_q[SAMPLE_W-2:0]};
        sum = {1'b0, acc_q} + {1'b0, u};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            dac_q <= 1'b0;
        end else if (enable_i) begin
            acc_q <= sum[SAMPLE_W-1:0];
            dac_q <= sum[SAMPLE_W];
        end else begin
            // Restart from a known phase on re-enable.
            acc_q <= '0;
            dac_q <= 1'b0;
        end
    end

    assign dac_o   = dac_q;
    assign gain_o  = gain_q;
    assign muted_o = muted_q;

endmodule

// File: tb/tb_audio_dac_out.sv
// ---------------------------------------------------------------------------
// tb_audio_dac_out
//
// Directed bench for audio_dac_out. Stimulus pushes the expected gain (after
// the capture edge) and expected scaled value (one clock later) into queues;
// a monitor process pops and compares whenever it sees an accepted sample.
// Bitstream density and reset/enable behaviour are checked in the main flow.
// ---------------------------------------------------------------------------
module tb_audio_dac_out;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic signed [SAMPLE_W-1:0] sample = '0;
    logic                       sample_valid = 1'b0;
    logic        [GAIN_W-1:0]   volume = '0;
    logic                       mute = 1'b0;
    logic                       enable = 1'b0;
    logic                       dac;
    logic        [GAIN_W-1:0]   gain;
    logic                       muted;

    int checks = 0;
    int errors = 0;

    int exp_gain_q[$];
    int exp_scaled_q[$];

    audio_dac_out #(
        .SAMPLE_W(SAMPLE_W),
        .GAIN_W  (GAIN_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sample_i      (sample),
        .sample_valid_i(sample_valid),
        .volume_i      (volume),
        .mute_i        (mute),
        .enable_i      (enable),
        .dac_o         (dac),
        .gain_o        (gain),
        .muted_o       (muted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one accepted sample (back-to-back when called repeatedly).
    task automatic pulse(input logic [SAMPLE_W-1:0] s, input int eg, input int es);
        @(negedge clk);
        sample       = s;
        sample_valid = 1'b1;
        exp_gain_q.push_back(eg);
        exp_scaled_q.push_back(es);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            ones += int'(dac);
        end
    endtask

    // Monitor: gain/muted one edge after acceptance, scaled_q one edge later.
    initial begin
        bit v0;
        bit v_p1;
        int e;
        v_p1 = 1'b0;
        forever begin
            @(posedge clk);
            v0 = sample_valid;
            #1;
            if (rst) begin
                v_p1 = 1'b0;
            end else begin
                if (v_p1) begin
                    if (exp_scaled_q.size() == 0) begin
                        chk("scaled_queue_empty", 1, 0);
                    end else begin
                        e = exp_scaled_q.pop_front();
                        chk("scaled", int'($signed(dut.scaled_q)), e);
                    end
                end
                if (v0) begin
                    if (exp_gain_q.size() == 0) begin
                        chk("gain_queue_empty", 1, 0);
                    end else begin
                        e = exp_gain_q.pop_front();
                        chk("gain", int'(gain), e);
                        chk("muted", int'(muted), (e == 0) ? 1 : 0);
                    end
                end
                v_p1 = v0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        bit prev;

        // Reset state
        #12;
        chk("rst_gain", int'(gain), 0);
        chk("rst_muted", int'(muted), 1);
        chk("rst_dac", int'(dac), 0);

        // Idle midscale: 0,1,0,1,... from the first enabled clock
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("idle_dac", int'(dac), k % 2);
        end
        chk("idle_muted", int'(muted), 1);
        chk("idle_gain", int'(gain), 0);

        // Ramp up with back-to-back pulses; 16th pulse holds at 15
        volume = 4'd15;
        for (int i = 1; i <= 16; i++) begin
            pulse(16'h0000, (i > 15) ? 15 : i, 0);
        end

        // Full-scale positive at gain 15
        pulse(16'h7FFF, 15, 30719);
        idle(3);
        count_ones(65536, ones);
        chk("ones_pos_full", ones, 63487);

        // Full-scale negative at gain 15 (u = 2048, period 32)
        pulse(16'h8000, 15, -30720);
        idle(3);
        count_ones(4096, ones);
        chk("ones_neg_full", ones, 128);

        // Mute: ramp down 14..0 then stays at 0; sample 0x4000 -> 1024*g
        @(negedge clk);
        mute = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            pulse(16'h4000, (i < 15) ? 15 - i : 0, (i < 15) ? 1024 * (15 - i) : 0);
        end
        idle(3);
        chk("mute_muted", int'(muted), 1);
        @(posedge clk);
        #1;
        prev = dac;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("mute_toggle", int'(dac), int'(!prev));
            prev = dac;
        end

        // Enable drop and restart from acc=0
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("disable_dac", int'(dac), 0);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("reenable_dac0", int'(dac), 0);
        @(posedge clk);
        #1;
        chk("reenable_dac1", int'(dac), 1);

        // Ramp to 7, then asynchronous reset mid-cycle
        @(negedge clk);
        mute = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            pulse(16'h4000, i, 1024 * i);
        end
        idle(3);
        chk("pre_rst_gain", int'(gain), 7);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_gain", int'(gain), 0);
        chk("async_rst_muted", int'(muted), 1);
        chk("async_rst_dac", int'(dac), 0);
        chk("async_rst_acc", int'(dut.acc_q), 0);
        @(negedge clk);
        rst = 1'b0;

        // Next sample restarts from gain 0
        pulse(16'h4000, 1, 1024);
        idle(3);
        chk("gain_queue_drained", exp_gain_q.size(), 0);
        chk("scaled_queue_drained", exp_scaled_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
